// File: rtl/trap_unit_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, CSR op
// encoding, interrupt cause codes, trap FSM states and the CSR update rule.
`default_nettype none

package trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_SW    = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2,
    ST_SETTLE = 2'd3
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_RW:  csr_apply = wdata;
      CSR_RS:  csr_apply = old_val | wdata;
      CSR_RC:  csr_apply = old_val & ~wdata;
      default: csr_apply = old_val;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_unit_irq_sync.sv
// Single register stage on the three level-sensitive interrupt request lines.
`default_nettype none

module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic ext_irq,
  input  logic sw_irq,
  input  logic timer_irq,
  output logic ext_q,
  output logic sw_q,
  output logic timer_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      sw_q    <= 1'b0;
      timer_q <= 1'b0;
    end else begin
      ext_q   <= ext_irq;
      sw_q    <= sw_irq;
      timer_q <= timer_irq;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_unit.sv
// Machine-mode trap unit: interrupt CSRs, interrupt entry and MRET return,
// with registered one-cycle redirect pulses to the pipeline controller.
`default_nettype none

module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_write,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        is_mret_instr,
  input  logic        instr_valid_mem,
  input  logic [31:0] pc_mem,
  input  logic        stall_pipl,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        timer_irq,
  output logic        trap_taken,
  output logic        mret_exec,
  output logic [31:0] redirect_pc
);

  trap_state_e state;
  logic        st_mie, st_mpie;
  logic        msie, mtie, meie;
  logic        sw_q, timer_q, ext_q;
  logic [31:0] mepc, mcause, mtvec;
  logic [31:0] mstatus_val, mie_val, mip_val, pending, csr_new, cause_sel;
  logic        advance, irq_req, take_mret, take_trap, csr_wr_en;

  irq_sync u_irq_sync (
    .clk       (clk),
    .reset     (reset),
    .ext_irq   (ext_irq),
    .sw_irq    (sw_irq),
    .timer_irq (timer_irq),
    .ext_q     (ext_q),
    .sw_q      (sw_q),
    .timer_q   (timer_q)
  );

  assign mstatus_val = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
  assign mie_val     = {20'd0, meie, 3'd0, mtie, 3'd0, msie, 3'd0};
  assign mip_val     = {20'd0, ext_q, 3'd0, timer_q, 3'd0, sw_q, 3'd0};
  assign pending     = mip_val & mie_val;

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_val;
      CSR_MIE:     csr_rdata = mie_val;
      CSR_MIP:     csr_rdata = mip_val;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      default:     csr_rdata = 32'd0;
    endcase
  end

  always_comb begin
    cause_sel = MCAUSE_TIMER;
    if (pending[11])     cause_sel = MCAUSE_EXT;
    else if (pending[3]) cause_sel = MCAUSE_SW;
  end

  assign csr_new   = csr_apply(csr_op_e'(csr_op), csr_rdata, csr_wdata);
  assign advance   = instr_valid_mem && !stall_pipl;
  assign irq_req   = st_mie && (pending != 32'd0);
  assign take_mret = (state == ST_IDLE) && advance && is_mret_instr;
  assign take_trap = (state == ST_IDLE) && advance && irq_req && !is_mret_instr;
  // Writes only land from IDLE; the trapping instruction's own write is dropped.
  assign csr_wr_en = (state == ST_IDLE) && advance && csr_write && !take_trap && !take_mret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      msie        <= 1'b0;
      mtie        <= 1'b0;
      meie        <= 1'b0;
      mepc        <= 32'd0;
      mcause      <= 32'd0;
      mtvec       <= RESET_MTVEC & ~32'h3;
      trap_taken  <= 1'b0;
      mret_exec   <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      trap_taken  <= 1'b0;
      mret_exec   <= 1'b0;
      redirect_pc <= 32'd0;
      if (csr_wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
          end
          CSR_MIE: begin
            msie <= csr_new[3];
            mtie <= csr_new[7];
            meie <= csr_new[11];
          end
          CSR_MTVEC:  mtvec  <= csr_new & ~32'h3;
          CSR_MEPC:   mepc   <= csr_new & ~32'h3;
          CSR_MCAUSE: mcause <= csr_new;
          default: ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (take_mret) begin
            state       <= ST_RETURN;
            mret_exec   <= 1'b1;
            redirect_pc <= mepc;
            st_mie      <= st_mpie;
            st_mpie     <= 1'b1;
          end else if (take_trap) begin
            state       <= ST_ENTER;
            trap_taken  <= 1'b1;
            redirect_pc <= mtvec;
            mepc        <= pc_mem & ~32'h3;
            mcause      <= cause_sel;
            st_mpie     <= st_mie;
            st_mie      <= 1'b0;
          end
        end
        ST_ENTER, ST_RETURN: state <= ST_SETTLE;
        ST_SETTLE: if (advance) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
